// File: rtl/regfile_read_port.sv
// Dual read port for the register file: one-cycle registered operand response with
// valid/ready handshake, same-cycle write bypass and a sticky malformed-write flag.
module regfile_read_port #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter bit ZERO_HARD = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [(2**AW)*DW-1:0]   reg_bus,
    input  logic                    wr_en,
    input  logic [(2**AW)-1:0]      wr_onehot,
    input  logic [DW-1:0]           wr_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AW-1:0]           ra,
    input  logic [AW-1:0]           rb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_a,
    output logic [DW-1:0]           rsp_b,
    input  logic                    err_clear,
    output logic                    onehot_err
);

    localparam int NREG = 2**AW;

    logic [DW-1:0] regs [NREG];
    logic          onehot_ok;
    logic          wr_ok;
    logic          err_set;
    logic          accept;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    for (genvar g = 0; g < NREG; g++) begin : g_unpack
        assign regs[g] = reg_bus[g*DW +: DW];
    end

    // wr_onehot is only qualified by wr_en, so undriven select lines are harmless when idle
    assign onehot_ok = (wr_onehot != '0) && ((wr_onehot & (wr_onehot - 1'b1)) == '0);
    assign wr_ok     = wr_en && onehot_ok;
    assign err_set   = wr_en && !onehot_ok;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        op_a = regs[ra];
        op_b = regs[rb];
        if (wr_ok && wr_onehot[ra]) op_a = wr_data;
        if (wr_ok && wr_onehot[rb]) op_b = wr_data;
        if (ZERO_HARD && (ra == '0)) op_a = '0;
        if (ZERO_HARD && (rb == '0)) op_b = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_a     <= op_a;
            rsp_b     <= op_b;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // set has priority over clear so a fault in the clearing cycle is not lost
    always_ff @(posedge clk) begin
        if (reset)          onehot_err <= 1'b0;
        else if (err_set)   onehot_err <= 1'b1;
        else if (err_clear) onehot_err <= 1'b0;
    end

endmodule
